// File: rtl/status_frame_tx_if.sv
// DSP-bound byte link: parallel byte with valid/ack handshake.
// The transmitter drives byte and valid; the DSP answers with ack.
interface status_frame_tx_if;
    logic [7:0] DSPuitgang;
    logic       DSPvalid;
    logic       DSPack;

    modport master (output DSPuitgang, output DSPvalid, input DSPack);
    modport slave  (input DSPuitgang, input DSPvalid, output DSPack);
endinterface

// File: rtl/status_frame_tx.sv
// Status frame transmitter: snapshots system status and sends a 5-byte
// frame (sync, heart, ctrl/stress, error/seq, xor checksum) to the DSP.
module status_frame_tx #(
    parameter int unsigned PERIOD  = 1000,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic                      clk,
    input  logic                      extReset,
    input  logic                      start,
    input  logic [7:0]                hartData,
    input  logic [2:0]                amp,
    input  logic [2:0]                freq,
    input  logic                      stressLaag,
    input  logic                      stressContinu,
    input  logic                      errorIn,
    status_frame_tx_if.master         dsp,
    output logic                      busy,
    output logic                      frameDone,
    output logic                      txError
);
    localparam int unsigned TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (PERIOD > 0) ? TMR_W'(PERIOD - 1) : '0;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PRESENT, GAP, DONE} state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             pend_q, pend_d;
    logic [6:0]       seq_q, seq_d;
    logic [7:0]       snap_hd_q, snap_hd_d;
    logic [7:0]       snap_b2_q, snap_b2_d;
    logic             snap_err_q, snap_err_d;
    logic [7:0]       out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             txerr_q, txerr_d;

    logic             period_tick;
    logic             req;
    logic             accept;
    logic [7:0]       b3, chk;

    always_comb begin
        period_tick = (PERIOD != 0) && (tmr_q == TMR_LAST);
        req         = start | period_tick;
        accept      = (state_q == PRESENT) & valid_q & dsp.DSPack;

        state_d    = state_q;
        idx_d      = idx_q;
        to_cnt_d   = to_cnt_q;
        pend_d     = pend_q;
        seq_d      = seq_q;
        snap_hd_d  = snap_hd_q;
        snap_b2_d  = snap_b2_q;
        snap_err_d = snap_err_q;
        txerr_d    = 1'b0;
        tmr_d      = (PERIOD == 0 || period_tick) ? '0 : tmr_q + TMR_W'(1);

        if (req && state_q != IDLE) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (req || pend_q) begin
                    state_d    = PRESENT;
                    idx_d      = 3'd0;
                    to_cnt_d   = '0;
                    pend_d     = 1'b0;
                    snap_hd_d  = hartData;
                    snap_b2_d  = {amp, freq, stressLaag, stressContinu};
                    snap_err_d = errorIn;
                end
            end
            PRESENT: begin
                // ack on the last allowed cycle still wins over the abort
                if (accept) begin
                    state_d = (idx_q == 3'd4) ? DONE : GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    txerr_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            GAP: begin
                state_d  = PRESENT;
                idx_d    = idx_q + 3'd1;
                to_cnt_d = '0;
            end
            DONE: begin
                state_d = IDLE;
                seq_d   = seq_q + 7'd1;
            end
            default: state_d = IDLE;
        endcase

        b3  = {snap_err_d, seq_q};
        chk = SYNC ^ snap_hd_d ^ snap_b2_d ^ b3;

        // outputs are registered, so they are decoded from the next state
        valid_d = (state_d == PRESENT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        out_d   = '0;
        if (valid_d) begin
            case (idx_d)
                3'd0:    out_d = SYNC;
                3'd1:    out_d = snap_hd_d;
                3'd2:    out_d = snap_b2_d;
                3'd3:    out_d = b3;
                default: out_d = chk;
            endcase
        end
    end

    always_ff @(posedge clk or negedge extReset) begin
        if (!extReset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            to_cnt_q   <= '0;
            tmr_q      <= '0;
            pend_q     <= 1'b0;
            seq_q      <= '0;
            snap_hd_q  <= '0;
            snap_b2_q  <= '0;
            snap_err_q <= 1'b0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            txerr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            to_cnt_q   <= to_cnt_d;
            tmr_q      <= tmr_d;
            pend_q     <= pend_d;
            seq_q      <= seq_d;
            snap_hd_q  <= snap_hd_d;
            snap_b2_q  <= snap_b2_d;
            snap_err_q <= snap_err_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            txerr_q    <= txerr_d;
        end
    end

    assign dsp.DSPuitgang = out_q;
    assign dsp.DSPvalid   = valid_q;
    assign busy           = busy_q;
    assign frameDone      = done_q;
    assign txError        = txerr_q;

endmodule

// File: doc/status_frame_tx.md
Name: status_frame_tx

Overview:
Transmit-side counterpart of the DSP byte-input path. Periodically or on request, snapshots the system status and sends it to the DSP as a 5-byte frame. Status covers heart data, controller amp/freq, the stress flags and the error flag. Uses a parallel byte plus valid/ack handshake, the reverse direction of the DSP data/ready input. Sits beside the stress and controller blocks in the top level and drives the DSP-bound pins.

Parameters:
PERIOD, 1000, clock cycles between automatic frame requests; 0 disables automatic requests
TIMEOUT, 255, max cycles DSPvalid may stay high without DSPack before the frame is aborted (≥1)
SYNC, 8'hA5, frame start byte

Ports:
clk  input  1  system clock, all logic on rising edge
extReset  input  1  asynchronous, active-low reset
start  input  1  one-cycle frame request
hartData  input  8  heart-rate data
amp  input  3  controller amplitude
freq  input  3  controller frequency
stressLaag  input  1  low-stress flag
stressContinu  input  1  continuous-stress flag
errorIn  input  1  system error flag
DSPack  input  1  DSP accepts current byte
DSPuitgang  output  8  byte to DSP
DSPvalid  output  1  DSPuitgang valid
busy  output  1  frame in progress
frameDone  output  1  one-cycle pulse, frame fully accepted
txError  output  1  one-cycle pulse, frame aborted on timeout

Behaviour:
- Reset (extReset=0, async): all outputs 0. Sequence counter, period timer, pending flag, byte index and timeout counter are all 0. FSM goes to IDLE.
- Request sources:
  - req = start OR periodTick.
  - periodTick pulses when the free-running period timer wraps at PERIOD-1. The timer runs in all states.
  - Request in IDLE: frame starts.
  - Request while busy: sets a one-deep pending flag; multiple requests collapse into one. Pending is served on the first IDLE cycle and cleared when that frame starts.
- Snapshot: all status inputs are registered on the edge where the FSM leaves IDLE. Frame content is frozen for the whole frame.
- Frame bytes:
  - B0 = SYNC
  - B1 = hartData
  - B2 = {amp[2:0], freq[2:0], stressLaag, stressContinu}
  - B3 = {errorIn, seq[6:0]}
  - B4 = B0^B1^B2^B3
- FSM states: IDLE, PRESENT, GAP, DONE.
  - IDLE: busy=0. On req or pending → PRESENT with index 0. DSPvalid rises the cycle after the request edge, so latency is 1 cycle.
  - PRESENT: DSPvalid=1, DSPuitgang = byte[index], stable.
    - Accept = DSPvalid & DSPack on a rising edge.
    - On accept with index<4 → GAP.
    - On accept with index=4 → DONE.
  - GAP: DSPvalid=0 for exactly one cycle, index+1, then → PRESENT.
  - DONE: frameDone=1 for one cycle, seq increments (wraps 127→0), → IDLE.
  - busy=1 in PRESENT, GAP and DONE.
- Timeout:
  - Counter clears on entering PRESENT and counts each PRESENT cycle without ack.
  - If it reaches TIMEOUT with DSPack low: DSPvalid drops next cycle, txError pulses one cycle, FSM → IDLE.
  - seq is not incremented and the pending flag is kept.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins, and the byte is accepted.
- DSPack outside PRESENT is ignored.
- DSPuitgang is 0 whenever DSPvalid=0.
- Reset asserted mid-frame: immediate return to the reset state. No frameDone or txError pulse.

Test Plan:
1. Basic frame:
   - Stimulus: after reset, hartData=0x48, amp=3'b101, freq=3'b011, stressLaag=1, stressContinu=0, errorIn=0, DSPack tied 1, pulse start.
   - Required: bytes A5, 48, AE, 00, 43 with valid 1,0,1,0,… gaps; frameDone one cycle after B4 accept; busy low next cycle.
2. Snapshot and sequence:
   - Stimulus: change hartData to 0x10 mid-frame, then send a second frame.
   - Required: first frame still carries 0x48; second frame B3=0x01 and checksum recomputed; seq wraps to 0 after 128 completed frames.
3. Backpressure:
   - Stimulus: hold DSPack=0 for 10 cycles on B2, then raise it.
   - Required: B2 stable and DSPvalid high throughout; frame completes normally.
4. Timeout:
   - Stimulus: TIMEOUT=4, DSPack=0 on B1.
   - Required: txError pulses after 4 PRESENT cycles; DSPvalid=0; busy=0; seq unchanged; next frame B3 seq equals the old value.
5. Request collapse and periodic:
   - Stimulus: PERIOD=100; three start pulses during a frame.
   - Required: exactly one extra frame follows; automatic frames start every 100 cycles when idle.
6. Async reset mid-frame:
   - Stimulus: drop extReset during B3.
   - Required: all outputs 0 immediately, no frameDone; after release, the next frame has seq=0.
